bus_datapath_seq: RTL and testbench

Parametrised successor of the 16-bit, 8-register bus datapath. Width and register count are configurable, and the tri-state bus is replaced by a one-hot-select multiplexed bus. The datapath is paired with a self-contained multicycle sequencer that accepts one instruction per valid/ready handshake. The block sits between an external fetch unit, which supplies instruction words and immediates, and the debug/LED observation logic.

---
 rtl/bus_datapath_seq.sv | 95 +++++++++
 tb/tb_bus_datapath_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: parametrised mux-bus register datapath with a multicycle valid/ready sequencer.
// Define BUS_DATAPATH_FLAGS_EN to implement the flags register and the CMP opcode.
module bus_datapath_seq #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int RSEL_W  = $clog2(NREGS),
  parameter int INSTR_W = 4 + 2*RSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  imm,
  output logic               done,
  output logic               illegal,
  output logic [2:0]         flags,
  output logic [DATA_W-1:0]  bus,
  output logic [1:0]         state,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q, g_q, imm_q, alu_r;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0] op;
  logic [RSEL_W-1:0] rx, ry;
  logic is_mv, is_mvi, is_cmp, is_alu, wr_en, ld_a, ld_g, accept;
  assign {op, rx, ry} = ir_q;
  assign is_mv  = op == 4'd0;
  assign is_mvi = op == 4'd1;
`ifdef BUS_DATAPATH_FLAGS_EN
  assign is_cmp = op == 4'd7;
`else
  assign is_cmp = 1'b0;
`endif
  assign is_alu   = (op >= 4'd2 && op <= 4'd6) || is_cmp;
  assign accept   = instr_ready && instr_valid;
  assign state    = state_q;
  assign dbg_data = regs[dbg_sel];
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (instr_valid ? T1 : IDLE) :
              state_q == T1   ? (is_alu ? T2 : IDLE) :
              state_q == T2   ? (is_cmp ? IDLE : T3) : IDLE;
  always_comb begin
    instr_ready = state_q == IDLE;
    ld_a        = state_q == T1 && is_alu;
    ld_g        = state_q == T2;
    illegal     = state_q == T1 && !is_mv && !is_mvi && !is_alu;
    done        = (state_q == T1 && !is_alu) || (state_q == T2 && is_cmp) || state_q == T3;
    wr_en       = (state_q == T1 && (is_mv || is_mvi)) || state_q == T3;
    bus         = state_q == T1 ? (is_mv ? regs[ry] : is_mvi ? imm_q : is_alu ? regs[rx] : '0) :
                  state_q == T2 ? regs[ry] :
                  state_q == T3 ? g_q : '0;
  end
  always_comb
    alu_r = op == 4'd2 ? a_q + bus :
            (op == 4'd3 || op == 4'd7) ? a_q - bus :
            op == 4'd4 ? a_q & bus :
            op == 4'd5 ? a_q | bus : a_q ^ bus;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      g_q   <= '0;
    end else begin
      if (accept) ir_q <= instr;
      if (accept) imm_q <= imm;
      if (ld_a) a_q <= bus;
      if (ld_g) g_q <= alu_r;
    end
  // All writebacks take the bus value: R[ry] for MV, IMM for MVI, G in T3.
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wr_en) regs[rx] <= bus;
`ifdef BUS_DATAPATH_FLAGS_EN
  logic [2:0] flags_q;
  logic carry_n;
  // Add carries out exactly when the truncated sum wraps below an operand.
  assign carry_n = op == 4'd2 ? alu_r < a_q :
                   (op == 4'd3 || op == 4'd7) ? a_q >= bus : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) flags_q <= '0;
    else if (ld_g) flags_q <= {carry_n, alu_r[DATA_W-1], alu_r == '0};
  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif
endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq: directed checks of bus_datapath_seq (DATA_W=16, NREGS=8).
module tb_bus_datapath_seq;
`ifdef BUS_DATAPATH_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, instr_valid = 1'b0;
  logic instr_ready, done, illegal;
  logic [9:0] instr = '0;
  logic [15:0] imm = '0, bus, dbg_data;
  logic [2:0] flags, dbg_sel = '0;
  logic [1:0] state;
  logic [15:0] model [8];
  int checks = 0, errors = 0;
  bus_datapath_seq #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .done(done), .illegal(illegal), .flags(flags),
    .bus(bus), .state(state), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input int r, input logic [15:0] e);
    dbg_sel = 3'(r);
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, e});
  endtask
  task automatic all_regs(input string tag);
    for (int r = 0; r < 8; r++) rd_chk($sformatf("%s R%0d", tag, r), r, model[r]);
  endtask
  task automatic issue(input string tag, input logic [3:0] op, input int rx, input int ry,
                       input logic [15:0] im, input int lat, input logic ill, output logic [15:0] b);
    int cyc;
    @(negedge clk);
    chk({tag, " ready"}, instr_ready, 1);
    instr = {op, 3'(rx), 3'(ry)};
    imm = im;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " illegal"}, illegal, ill);
    b = bus;
  endtask
  initial begin
    logic [15:0] b;
    int acc, bad, saw_done;
    #3 rst = 1'b1;
    #2;
    chk("reset state", state, 0);
    chk("reset done", done, 0);
    chk("reset bus", bus, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) model[r] = '0;
    all_regs("reset");
    chk("reset ready", instr_ready, 1);
    chk("reset flags", flags, 0);
    issue("mvi r1", 4'd1, 1, 0, 16'h0005, 1, 1'b0, b);
    chk("mvi bus", b, 16'h0005);
    issue("mvi r2", 4'd1, 2, 0, 16'hFFFE, 1, 1'b0, b);
    issue("add r1 r2", 4'd2, 1, 2, 16'h0000, 3, 1'b0, b);
    @(negedge clk);
    model[1] = 16'h0003;
    model[2] = 16'hFFFE;
    rd_chk("add r1", 1, 16'h0003);
    rd_chk("add r2 kept", 2, 16'hFFFE);
    chk("add flags", flags, FE ? 3'b100 : 3'b000);
    issue("mvi r3", 4'd1, 3, 0, 16'hFFFF, 1, 1'b0, b);
    issue("mvi r4", 4'd1, 4, 0, 16'h0001, 1, 1'b0, b);
    issue("add r3 r4", 4'd2, 3, 4, 16'h0000, 3, 1'b0, b);
    @(negedge clk);
    model[3] = 16'h0000;
    rd_chk("wrap r3", 3, 16'h0000);
    chk("wrap flags", flags, FE ? 3'b101 : 3'b000);
    issue("sub r4 r4", 4'd3, 4, 4, 16'h0000, 3, 1'b0, b);
    @(negedge clk);
    model[4] = 16'h0000;
    rd_chk("sub r4", 4, 16'h0000);
    chk("sub flags", flags, FE ? 3'b101 : 3'b000);
    issue("mvi r5", 4'd1, 5, 0, 16'h0002, 1, 1'b0, b);
    issue("mvi r6", 4'd1, 6, 0, 16'h0003, 1, 1'b0, b);
    model[5] = 16'h0002;
    model[6] = 16'h0003;
    issue("cmp r5 r6", 4'd7, 5, 6, 16'h0000, FE ? 2 : 1, !FE, b);
    @(negedge clk);
    rd_chk("cmp r5 kept", 5, 16'h0002);
    chk("cmp flags", flags, FE ? 3'b010 : 3'b000);
    issue("mv r0 r5", 4'd0, 0, 5, 16'h1234, 1, 1'b0, b);
    chk("mv bus", b, 16'h0002);
    @(negedge clk);
    model[0] = 16'h0002;
    rd_chk("mv r0", 0, 16'h0002);
    @(negedge clk);
    instr = {4'd2, 3'd7, 3'd2};
    instr_valid = 1'b1;
    acc = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (instr_ready) acc++;
      if (instr_ready !== (i % 4 == 0)) bad++;
    end
    instr_valid = 1'b0;
    chk("held valid accepts", acc, 2);
    chk("ready low while busy", bad, 0);
    @(negedge clk);
    model[7] = 16'hFFFC;
    chk("held valid idle", state, 0);
    rd_chk("held valid r7", 7, 16'hFFFC);
    chk("held valid flags", flags, FE ? 3'b110 : 3'b000);
    issue("illegal op F", 4'hF, 1, 2, 16'hAAAA, 1, 1'b1, b);
    chk("illegal done", done, 1);
    @(negedge clk);
    all_regs("after illegal");
    @(negedge clk);
    instr = {4'd2, 3'd1, 3'd2};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort in T2", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("abort state", state, 0);
    chk("abort done", done, 0);
    chk("abort bus", bus, 0);
    chk("abort flags", flags, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    chk("abort no done", saw_done, 0);
    chk("abort ready", instr_ready, 1);
    for (int r = 0; r < 8; r++) model[r] = '0;
    all_regs("after abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
